// File: rtl/sr_pkg.sv
// Shared types and widths for the SR command driver.
package sr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap,
    StCheck
  } state_e;

  // Width of the shared PW/GAP down-counter; PW and GAP must each fit in it.
  localparam int unsigned CNT_W = 8;

  // Width of the saturating error counter.
  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Capture stage followed by the settled output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Command-driven set/clear pulse generator for a bank of SR latches, with Q readback check.
module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int unsigned CH  = 4,
  parameter int unsigned CW  = (CH > 1) ? $clog2(CH) : 1,
  parameter int unsigned PW  = 3,
  parameter int unsigned GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_ch,
  input  logic                 cmd_val,
  output logic [CH-1:0]        s_out,
  output logic [CH-1:0]        r_out,
  input  logic [CH-1:0]        q_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic                 val_q, val_d;
  logic                 oor_q, oor_d;
  logic [CH-1:0]        s_q, s_d, r_q, r_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CH-1:0]        q_sync;
  logic                 cmd_oor;
  logic                 q_sel;
  logic                 chk_err;

  sync2 #(
    .W(CH)
  ) u_q_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (q_in),
    .q    (q_sync)
  );

  // Compare in 32 bits so non-power-of-two CH can flag unused indices.
  assign cmd_oor = (32'(cmd_ch) >= CH);

  // Select the synchronized Q of the latched channel; out-of-range reads 0 and is flagged anyway.
  always_comb begin
    q_sel = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      if (ch_q == CW'(i)) q_sel = q_sync[i];
    end
  end

  assign chk_err = oor_q | (q_sel != val_q);

  // Next-state, shared counter, command latch, error counter and registered S/R decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    val_d     = val_q;
    oor_d     = oor_q;
    err_cnt_d = err_cnt_q;
    s_d       = '0;
    r_d       = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ch_d  = cmd_ch;
          val_d = cmd_val;
          oor_d = cmd_oor;
          if (cmd_oor) begin
            state_d = StCheck;
          end else begin
            state_d = StPulse;
            cnt_d   = PW_LOAD;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StCheck;
        else cnt_d = cnt_q - 1'b1;
      end
      StCheck: begin
        state_d = StIdle;
        if (chk_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Drive S/R only for cycles that will be spent in PULSE, so the registered outputs align.
    if (state_d == StPulse) begin
      for (int i = 0; i < int'(CH); i++) begin
        if (ch_d == CW'(i)) begin
          s_d[i] = val_d;
          r_d[i] = ~val_d;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ch_q      <= '0;
      val_q     <= 1'b0;
      oor_q     <= 1'b0;
      s_q       <= '0;
      r_q       <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      val_q     <= val_d;
      oor_q     <= oor_d;
      s_q       <= s_d;
      r_q       <= r_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StCheck);
  assign err       = done & chk_err;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Self-checking bench for sr_cmd_driver: directed cases plus randomized back-to-back stress.
module tb_sr_cmd_driver;

  localparam int PW  = 3;
  localparam int GAP = 2;
  localparam int LAST = PW + GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic       cmd_val;
  logic [3:0] s_out, r_out, q_in;
  logic       busy, done, err;
  logic [7:0] err_cnt;

  logic       v3;
  logic       rdy3;
  logic [1:0] ch3;
  logic       val3;
  logic [2:0] s3, r3, q3;
  logic       busy3, done3, err3;
  logic [7:0] cnt3;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  // Latch bank model driving q_in; a stuck channel ignores S/R.
  logic [3:0] q_lat = '0;
  logic       stuck_en = 1'b0;
  logic [1:0] stuck_ch = '0;

  always #5 clk = ~clk;

  sr_cmd_driver #(
    .CH (4),
    .PW (PW),
    .GAP(GAP)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_val  (cmd_val),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  sr_cmd_driver #(
    .CH (3),
    .PW (PW),
    .GAP(GAP)
  ) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(v3),
    .cmd_ready(rdy3),
    .cmd_ch   (ch3),
    .cmd_val  (val3),
    .s_out    (s3),
    .r_out    (r3),
    .q_in     (q3),
    .busy     (busy3),
    .done     (done3),
    .err      (err3),
    .err_cnt  (cnt3)
  );

  assign q_in = q_lat;
  assign q3   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!(stuck_en && (int'(stuck_ch) == i))) begin
        if (s_out[i]) q_lat[i] <= 1'b1;
        else if (r_out[i]) q_lat[i] <= 1'b0;
      end
    end
  end

  // Safety invariants on both instances, every cycle.
  always @(negedge clk) begin
    check_eq("s_and_r", 32'(s_out & r_out), 32'd0);
    check_eq("sr_onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
    check_eq("s_and_r3", 32'(s3 & r3), 32'd0);
    check_eq("sr_onehot3", 32'($countones(s3 | r3) <= 1), 32'd1);
  end

  // One command on the main instance; leaves cmd_valid high at the CHECK cycle.
  task automatic do_cmd(input logic [1:0] ch, input logic val, input logic stuck);
    logic [3:0] exp_s, exp_r;
    logic       exp_err;
    logic       in_pulse;
    @(negedge clk);
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("err_cnt", 32'(err_cnt), 32'(model_cnt));
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_val   = val;
    stuck_en  = stuck;
    stuck_ch  = ch;
    exp_s     = val ? (4'b0001 << ch) : 4'b0000;
    exp_r     = val ? 4'b0000 : (4'b0001 << ch);
    exp_err   = stuck && (q_lat[ch] != val);
    for (int k = 1; k <= LAST; k++) begin
      @(negedge clk);
      in_pulse = (k <= PW);
      check_eq("s_out", 32'(s_out), 32'(in_pulse ? exp_s : 4'b0000));
      check_eq("r_out", 32'(r_out), 32'(in_pulse ? exp_r : 4'b0000));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("ready_low", 32'(cmd_ready), 32'd0);
      check_eq("done", 32'(done), 32'(k == LAST));
      check_eq("err", 32'(err), 32'((k == LAST) && exp_err));
    end
    if (exp_err && model_cnt < 255) model_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rch;
    logic       rval;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_val   = 1'b0;
    v3        = 1'b0;
    ch3       = '0;
    val3      = 1'b0;
    #12;
    check_eq("rst_s", 32'(s_out), 32'd0);
    check_eq("rst_r", 32'(r_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_ready3", 32'(rdy3), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Set channel 2 with a healthy latch, then a clear of channel 1 whose Q is stuck high.
    do_cmd(2'd2, 1'b1, 1'b0);
    do_cmd(2'd1, 1'b1, 1'b0);
    do_cmd(2'd1, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("clr_mismatch_cnt", 32'(err_cnt), 32'd1);

    // Out-of-range channel on the 3-channel instance.
    check_eq("oor_ready", 32'(rdy3), 32'd1);
    v3   = 1'b1;
    ch3  = 2'd3;
    val3 = 1'b1;
    @(negedge clk);
    check_eq("oor_done", 32'(done3), 32'd1);
    check_eq("oor_err", 32'(err3), 32'd1);
    check_eq("oor_s", 32'(s3), 32'd0);
    check_eq("oor_r", 32'(r3), 32'd0);
    check_eq("oor_busy", 32'(busy3), 32'd1);
    v3 = 1'b0;
    @(negedge clk);
    check_eq("oor_cnt", 32'(cnt3), 32'd1);
    check_eq("oor_ready_again", 32'(rdy3), 32'd1);
    check_eq("oor_done_low", 32'(done3), 32'd0);

    // Reset in the middle of a set pulse.
    stuck_en  = 1'b0;
    cmd_valid = 1'b1;
    cmd_ch    = 2'd2;
    cmd_val   = 1'b1;
    @(negedge clk);
    check_eq("rp_s_t1", 32'(s_out), 32'h4);
    @(negedge clk);
    check_eq("rp_s_t2", 32'(s_out), 32'h4);
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_eq("rp_s_async", 32'(s_out), 32'd0);
    check_eq("rp_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("rp_no_done", 32'(done), 32'd0);
      check_eq("rp_ready", 32'(cmd_ready), 32'd1);
    end

    // Randomized back-to-back commands with occasional stuck latches.
    for (int i = 0; i < 300; i++) begin
      rch  = 2'($urandom_range(3, 0));
      rval = 1'($urandom_range(1, 0));
      do_cmd(rch, rval, ($urandom_range(3, 0) == 0));
    end
    // Forced mismatches to drive the error counter into saturation.
    for (int i = 0; i < 300; i++) begin
      rch = 2'($urandom_range(3, 0));
      do_cmd(rch, ~q_lat[rch], 1'b1);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
